// File: rtl/ram_pkg.sv
// ram_pkg: shared constants, clear-FSM encoding and lane-count helper for the byte-enable RAM.
package ram_pkg;
  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST = 1;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;
  // Returns 0 when the word is not a whole number of lanes so the top can reject it.
  function automatic int lanes(input int dw, input int bw);
    return (bw > 0 && dw % bw == 0) ? dw / bw : 0;
  endfunction
endpackage

// File: rtl/ram_clear_sequencer.sv
// ram_clear_sequencer: sweeps every address once after reset or on request.
module ram_clear_sequencer import ram_pkg::*; #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clearStart,
  output logic                  busy,
  output logic                  clearDone,
  output logic [ADDR_WIDTH-1:0] clearAddr,
  output logic                  clearWrite
);
  localparam logic [ADDR_WIDTH:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
  clr_state_t state;
  logic [ADDR_WIDTH:0] ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      ptr <= '0;
      busy <= 1'b1;
      clearDone <= 1'b0;
    end else
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state <= DONE;
            busy <= 1'b0;
            clearDone <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          clearDone <= 1'b0;
        end
        default:
          if (clearStart) begin
            state <= CLEAR;
            ptr <= '0;
            busy <= 1'b1;
          end
      endcase
  assign clearAddr = ptr[ADDR_WIDTH-1:0];
  assign clearWrite = state == CLEAR;
endmodule

// File: rtl/dual_port_ram_be_clear.sv
// dual_port_ram_be_clear: true dual-port RAM with byte enables, selectable read-during-write
// and a hardware clear sweep that owns port A while busy.
module dual_port_ram_be_clear import ram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int RDW_MODE = RDW_WRITE_FIRST,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int NB = lanes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] dataA,
  input  logic [DATA_WIDTH-1:0] dataB,
  input  logic [NB-1:0]         byteEnA,
  input  logic [NB-1:0]         byteEnB,
  input  logic                  writeEnabledA,
  input  logic                  writeEnabledB,
  input  logic                  readEnabledA,
  input  logic                  readEnabledB,
  output logic [DATA_WIDTH-1:0] qA,
  output logic [DATA_WIDTH-1:0] qB,
  input  logic                  clearStart,
  output logic                  busy,
  output logic                  clearDone
);
  if (NB == 0) begin : g_width_check
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] clear_addr, wr_addr_a;
  logic [DATA_WIDTH-1:0] wr_data_a, new_a, new_b;
  logic [NB-1:0] wr_be_a;
  logic clear_write, wr_a, wr_b, rd_a, rd_b;
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                 input logic [DATA_WIDTH-1:0] new_w,
                                                 input logic [NB-1:0] be);
    for (int i = 0; i < NB; i++)
      if (be[i]) old_w[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
    return old_w;
  endfunction
  ram_clear_sequencer #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq (
    .clk, .rst, .clearStart, .busy, .clearDone,
    .clearAddr(clear_addr), .clearWrite(clear_write)
  );
  // The sweep borrows port A's write path; user traffic on both ports is gated while busy.
  always_comb begin
    wr_a = busy ? clear_write : writeEnabledA;
    wr_addr_a = busy ? clear_addr : addrA;
    wr_data_a = busy ? CLEAR_VALUE : dataA;
    wr_be_a = busy ? '1 : byteEnA;
    wr_b = writeEnabledB && !busy;
    rd_a = readEnabledA && !busy;
    rd_b = readEnabledB && !busy;
    new_a = (RDW_MODE == RDW_WRITE_FIRST && wr_a) ? merge(mem[addrA], dataA, byteEnA) : mem[addrA];
    new_b = (RDW_MODE == RDW_WRITE_FIRST && wr_b) ? merge(mem[addrB], dataB, byteEnB) : mem[addrB];
  end
  // Port A lanes are assigned last so they win lanes both ports enable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (wr_b && byteEnB[i]) mem[addrB][i*BYTE_WIDTH +: BYTE_WIDTH] <= dataB[i*BYTE_WIDTH +: BYTE_WIDTH];
    for (int i = 0; i < NB; i++)
      if (wr_a && wr_be_a[i]) mem[wr_addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      qA <= '0;
      qB <= '0;
    end else begin
      if (rd_a) qA <= new_a;
      if (rd_b) qB <= new_b;
    end
endmodule

// File: tb/tb_dual_port_ram_be_clear.sv
// tb_dual_port_ram_be_clear: write-first and read-first instances driven in lockstep
// and compared against an array-level reference model.
module tb_dual_port_ram_be_clear;
  localparam logic [31:0] CV = 32'hA5A5A5A5;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] addrA, addrB, byteEnA, byteEnB;
  logic [31:0] dataA, dataB;
  logic writeEnabledA, writeEnabledB, readEnabledA, readEnabledB, clearStart;
  logic [31:0] qa0, qb0, qa1, qb1;
  logic busy0, busy1, done0, done1;
  logic [31:0] mm [16];
  logic [31:0] eqa [2];
  logic [31:0] eqb [2];
  logic ebusy, edone;
  int eptr, checks = 0, errors = 0;
  always #5 clk = ~clk;
  dual_port_ram_be_clear #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RDW_MODE(0), .CLEAR_VALUE(CV)) u_wf (
    .clk, .rst, .addrA, .addrB, .dataA, .dataB, .byteEnA, .byteEnB, .writeEnabledA, .writeEnabledB,
    .readEnabledA, .readEnabledB, .qA(qa0), .qB(qb0), .clearStart, .busy(busy0), .clearDone(done0));
  dual_port_ram_be_clear #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RDW_MODE(1), .CLEAR_VALUE(CV)) u_rf (
    .clk, .rst, .addrA, .addrB, .dataA, .dataB, .byteEnA, .byteEnB, .writeEnabledA, .writeEnabledB,
    .readEnabledA, .readEnabledB, .qA(qa1), .qB(qb1), .clearStart, .busy(busy1), .clearDone(done1));
  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction
  task automatic idle();
    writeEnabledA = 0; writeEnabledB = 0; readEnabledA = 0; readEnabledB = 0; clearStart = 0;
    byteEnA = 0; byteEnB = 0; addrA = 0; addrB = 0; dataA = 0; dataB = 0;
  endtask
  task automatic model_reset();
    eqa[0] = 0; eqa[1] = 0; eqb[0] = 0; eqb[1] = 0; ebusy = 1; edone = 0; eptr = 0;
  endtask
  // Advances one clock; the model sees the same inputs the DUTs sample at this edge.
  task automatic step();
    logic [31:0] old [16];
    logic was_done;
    old = mm;
    if (ebusy) begin
      mm[eptr] = CV;
      eptr++;
      edone = 0;
      if (eptr == 16) begin ebusy = 0; edone = 1; end
    end else begin
      was_done = edone;
      edone = 0;
      if (readEnabledA) begin
        eqa[0] = writeEnabledA ? lane_merge(old[addrA], dataA, byteEnA) : old[addrA];
        eqa[1] = old[addrA];
      end
      if (readEnabledB) begin
        eqb[0] = writeEnabledB ? lane_merge(old[addrB], dataB, byteEnB) : old[addrB];
        eqb[1] = old[addrB];
      end
      if (writeEnabledB) mm[addrB] = lane_merge(mm[addrB], dataB, byteEnB);
      if (writeEnabledA) mm[addrA] = lane_merge(mm[addrA], dataA, byteEnA);
      if (clearStart && !was_done) begin ebusy = 1; eptr = 0; end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic write_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    idle(); addrA = a; dataA = d; byteEnA = be; writeEnabledA = 1;
    step();
    idle();
  endtask
  task automatic read_a(input logic [3:0] a);
    idle(); addrA = a; readEnabledA = 1;
    step();
    idle();
  endtask
  task automatic test_reset();
    int busy_n = 0, done_n = 0;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({qa0, qb0, qa1, qb1, busy0, done0} !== {128'h0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_values: got q=%h/%h/%h/%h busy=%b done=%b want zeros busy=1 done=0", qa0, qb0, qa1, qb1, busy0, done0);
    end
    rst = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy0) busy_n++;
      if (done0) done_n++;
      checks++;
      if ({busy0, busy1, done0, done1} !== {ebusy, ebusy, edone, edone}) begin
        errors++; $display("FAIL sweep_flags c=%0d: got busy=%b%b done=%b%b want busy=%b done=%b", c, busy0, busy1, done0, done1, ebusy, edone);
      end
      step();
    end
    checks++;
    if (busy_n != 16 || done_n != 1) begin
      errors++; $display("FAIL sweep_length: got busy cycles %0d done pulses %0d want 16 and 1", busy_n, done_n);
    end
    for (int a = 0; a < 16; a++) begin
      idle(); addrA = 4'(a); addrB = 4'(15 - a); readEnabledA = 1; readEnabledB = 1;
      step();
      checks++;
      if ({qa0, qb0, qa1, qb1} !== {4{CV}} || {qa0, qb0, qa1, qb1} !== {eqa[0], eqb[0], eqa[1], eqb[1]}) begin
        errors++; $display("FAIL clear_read a=%0d: got %h %h %h %h want %h", a, qa0, qb0, qa1, qb1, CV);
      end
    end
    idle();
  endtask
  task automatic test_byte_lane();
    write_a(3, 32'h0, 4'hF);
    write_a(3, 32'h11223344, 4'b0101);
    read_a(3);
    checks++;
    if (qa0 !== 32'h00220044 || qa1 !== 32'h00220044 || qa0 !== eqa[0]) begin
      errors++; $display("FAIL byte_lane: got %h/%h want 00220044", qa0, qa1);
    end
    write_a(3, 32'hFFFFFFFF, 4'b0000);
    read_a(3);
    checks++;
    if (qa0 !== 32'h00220044 || qa0 !== eqa[0]) begin
      errors++; $display("FAIL zero_byte_enable: got %h want 00220044", qa0);
    end
  endtask
  task automatic test_rdw();
    write_a(5, 32'hCAFEF00D, 4'hF);
    idle();
    addrB = 5; dataB = 32'hDEADBEEF; byteEnB = 4'hF; writeEnabledB = 1; readEnabledB = 1;
    addrA = 5; readEnabledA = 1;
    step();
    idle();
    checks++;
    if (qb0 !== 32'hDEADBEEF || qb0 !== eqb[0]) begin
      errors++; $display("FAIL rdw_write_first: got %h want deadbeef", qb0);
    end
    checks++;
    if (qb1 !== 32'hCAFEF00D || qb1 !== eqb[1]) begin
      errors++; $display("FAIL rdw_read_first: got %h want cafef00d", qb1);
    end
    checks++;
    if (qa0 !== 32'hCAFEF00D || qa1 !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rdw_cross_port: got %h/%h want cafef00d", qa0, qa1);
    end
    read_a(5);
    checks++;
    if (qa0 !== 32'hDEADBEEF || qa1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rdw_stored: got %h/%h want deadbeef", qa0, qa1);
    end
  endtask
  task automatic test_collision();
    write_a(7, 32'h5A5A5A5A, 4'hF);
    idle();
    addrA = 7; dataA = 32'hAAAAAAAA; byteEnA = 4'b0011; writeEnabledA = 1;
    addrB = 7; dataB = 32'hBBBBBBBB; byteEnB = 4'b0110; writeEnabledB = 1;
    step();
    read_a(7);
    checks++;
    if (qa0 !== 32'h5ABBAAAA || qa0 !== eqa[0]) begin
      errors++; $display("FAIL collision: got %h want 5abbaaaa", qa0);
    end
  endtask
  task automatic test_clear_request();
    int n = 0;
    write_a(2, 32'h01020304, 4'hF);
    read_a(2);
    idle(); clearStart = 1;
    step();
    idle();
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      errors++; $display("FAIL clear_start_busy: got %b%b want 1", busy0, busy1);
    end
    while (busy0 && n < 40) begin
      idle();
      addrA = 2; dataA = 32'hFFFFFFFF; byteEnA = 4'hF; writeEnabledA = 1; readEnabledA = 1;
      addrB = 9; dataB = 32'h12345678; byteEnB = 4'hF; writeEnabledB = 1; readEnabledB = 1;
      step();
      n++;
      checks++;
      if (qa0 !== 32'h01020304 || qa1 !== 32'h01020304 || qa0 !== eqa[0]) begin
        errors++; $display("FAIL busy_hold n=%0d: got %h/%h want 01020304", n, qa0, qa1);
      end
    end
    idle();
    checks++;
    if (n != 16 || done0 !== 1'b1 || edone !== 1'b1) begin
      errors++; $display("FAIL clear_request_len: got %0d cycles done=%b want 16 done=1", n, done0);
    end
    clearStart = 1;
    step();
    idle();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || busy0 !== ebusy) begin
      errors++; $display("FAIL start_in_done: got busy=%b done=%b want 0 0", busy0, done0);
    end
    read_a(2);
    checks++;
    if (qa0 !== CV || qa0 !== eqa[0]) begin
      errors++; $display("FAIL cleared_addr2: got %h want %h", qa0, CV);
    end
  endtask
  task automatic test_reset_mid_sweep();
    int n = 0;
    read_a(12);
    idle(); clearStart = 1;
    step();
    idle();
    repeat (9) step();
    #3 rst = 1;
    #1;
    checks++;
    if ({qa0, qa1, busy0, done0} !== {64'h0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_reset_async: got qa=%h/%h busy=%b done=%b want 0 busy=1 done=0", qa0, qa1, busy0, done0);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    while (!done0 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != 16 || edone !== 1'b1) begin
      errors++; $display("FAIL restart_len: got %0d cycles to done want 16", n);
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      addrA = 4'($urandom_range(0, 15)); addrB = 4'($urandom_range(0, 15));
      dataA = $urandom; dataB = $urandom;
      byteEnA = 4'($urandom); byteEnB = 4'($urandom);
      writeEnabledA = 1'($urandom); writeEnabledB = 1'($urandom);
      readEnabledA = 1'($urandom); readEnabledB = 1'($urandom);
      clearStart = ($urandom_range(0, 59) == 0);
      step();
      checks++;
      if ({qa0, qb0, qa1, qb1, busy0, busy1, done0, done1} !== {eqa[0], eqb[0], eqa[1], eqb[1], ebusy, ebusy, edone, edone}) begin
        errors++;
        $display("FAIL random c=%0d: got %h %h %h %h b=%b%b d=%b%b want %h %h %h %h b=%b d=%b", c, qa0, qb0, qa1, qb1,
                 busy0, busy1, done0, done1, eqa[0], eqb[0], eqa[1], eqb[1], ebusy, edone);
      end
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_byte_lane();
    test_rdw();
    test_collision();
    test_clear_request();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
